// File: rtl/scc_pkg.sv
// Shared constants for the register file and its writeback path.
package scc_pkg;
  localparam int   DATA_W     = 32;
  localparam int   REG_ADDR_W = 3;
  localparam int   NUM_REGS   = 8;
  localparam logic WB_SEL_ALU = 1'b1;
  localparam logic WB_SEL_ID  = 1'b0;
endpackage

// File: rtl/wb_load_fifo.sv
// Two-entry address+data buffer for load results waiting for a free write port.
module wb_load_fifo #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_value,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_value,
  output logic              empty,
  output logic              ready
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_addr_r  [DEPTH];
  logic [DATA_W-1:0] mem_value_r [DEPTH];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_next_s;

  assign count_next_s = count_r + CNT_W'(push) - CNT_W'(pop);
  assign empty        = (count_r == {CNT_W{1'b0}});
  assign head_addr    = mem_addr_r[rd_ptr_r];
  assign head_value   = mem_value_r[rd_ptr_r];

  // Storage, pointers and the registered ready flag (held low during reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_r[i]  <= '0;
        mem_value_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= '0;
      ready    <= 1'b0;
    end else begin
      if (push) begin
        mem_addr_r[wr_ptr_r]  <= push_addr;
        mem_value_r[wr_ptr_r] <= push_value;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_next_s;
      ready   <= (count_next_s < CNT_W'(DEPTH));
    end
  end
endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: merges ALU results and buffered loads into one registered
// register-file write per cycle and tracks pending writes for hazard stalls.
module reg_writeback #(
  parameter int DATA_W   = scc_pkg::DATA_W,
  parameter int ADDR_W   = scc_pkg::REG_ADDR_W,
  parameter int LD_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_value,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_value,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic                     stall,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     waw_err,
  output logic                     write_enable,
  output logic [ADDR_W-1:0]        write_addr,
  output logic [DATA_W-1:0]        write_value_alu,
  output logic [DATA_W-1:0]        write_value_id,
  output logic                     write_data_sel
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [NREG-1:0] BIT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic              fifo_empty_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_value_s;
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   set_mask_s;
  logic [NREG-1:0]   clr_mask_s;
  logic              waw_r;

  assign fifo_push_s = ld_valid & ld_ready;
  assign fifo_pop_s  = ~alu_valid & ~fifo_empty_s;

  wb_load_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (LD_DEPTH)
  ) u_load_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push       (fifo_push_s),
    .pop        (fifo_pop_s),
    .push_addr  (ld_addr),
    .push_value (ld_value),
    .head_addr  (head_addr_s),
    .head_value (head_value_s),
    .empty      (fifo_empty_s),
    .ready      (ld_ready)
  );

  // Write-port register: ALU wins outright, loads drain only in ALU-idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable    <= 1'b0;
      write_addr      <= '0;
      write_value_alu <= '0;
      write_value_id  <= '0;
      write_data_sel  <= scc_pkg::WB_SEL_ID;
    end else if (alu_valid) begin
      write_enable    <= 1'b1;
      write_addr      <= alu_addr;
      write_value_alu <= alu_value;
      write_data_sel  <= scc_pkg::WB_SEL_ALU;
    end else if (!fifo_empty_s) begin
      write_enable    <= 1'b1;
      write_addr      <= head_addr_s;
      write_value_id  <= head_value_s;
      write_data_sel  <= scc_pkg::WB_SEL_ID;
    end else begin
      write_enable    <= 1'b0;
    end
  end

  // A bit clears on the edge the register file captures it; a new issue wins.
  assign clr_mask_s = write_enable ? (BIT0 << write_addr) : {NREG{1'b0}};
  assign set_mask_s = issue_valid  ? (BIT0 << issue_addr) : {NREG{1'b0}};

  // Pending-write scoreboard and sticky WAW flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= '0;
      waw_r  <= 1'b0;
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
      waw_r  <= waw_r | (issue_valid & busy_r[issue_addr]);
    end
  end

  assign busy    = busy_r;
  assign waw_err = waw_r;
  assign stall   = busy_r[rd_addr1] | busy_r[rd_addr2] | busy_r[issue_addr];
endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: reference model of FIFO/arbiter/scoreboard
// plus a queue of expected register-file writes.
module tb_reg_writeback;
  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, ld_valid, issue_valid;
  logic [AW-1:0] alu_addr, ld_addr, issue_addr, rd_addr1, rd_addr2;
  logic [DW-1:0] alu_value, ld_value;
  logic          ld_ready, stall, waw_err, write_enable, write_data_sel;
  logic [7:0]    busy;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_value_alu, write_value_id;

  reg_writeback dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_value(alu_value),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_value(ld_value),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .stall(stall), .busy(busy), .waw_err(waw_err),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_value_alu(write_value_alu), .write_value_id(write_value_id),
    .write_data_sel(write_data_sel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [AW+DW-1:0]   m_fifo[$];
  logic [AW+DW:0]     exp_q[$];
  logic [AW+DW-1:0]   pend_ld[$];
  logic [7:0]    m_busy;
  logic          m_waw, m_ready, m_we, m_sel, m_accept;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_valu, m_vid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_fifo.delete(); exp_q.delete();
    m_busy = 8'h00; m_waw = 1'b0; m_ready = 1'b0; m_we = 1'b0; m_sel = 1'b0;
    m_waddr = '0; m_valu = '0; m_vid = '0; m_accept = 1'b0;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
    alu_addr = '0; ld_addr = '0; issue_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
    alu_value = '0; ld_value = '0;
  endtask

  task automatic compare_outputs();
    logic [AW+DW:0] e;
    check("write_enable", 64'(write_enable), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("wr_sel", 64'(write_data_sel), 64'(e[AW+DW]));
      check("wr_addr", 64'(write_addr), 64'(e[AW+DW-1:DW]));
      check("wr_value", 64'(e[AW+DW] ? write_value_alu : write_value_id), 64'(e[DW-1:0]));
    end
    check("hold_addr", 64'(write_addr), 64'(m_waddr));
    check("hold_alu", 64'(write_value_alu), 64'(m_valu));
    check("hold_id", 64'(write_value_id), 64'(m_vid));
    check("hold_sel", 64'(write_data_sel), 64'(m_sel));
    check("ld_ready", 64'(ld_ready), 64'(m_ready));
    check("busy", 64'(busy), 64'(m_busy));
    check("waw_err", 64'(waw_err), 64'(m_waw));
    check("stall", 64'(stall), 64'(m_busy[rd_addr1] | m_busy[rd_addr2] | m_busy[issue_addr]));
  endtask

  // Advance one clock: update model from current inputs, then compare after the edge.
  task automatic tick();
    logic [7:0] nb;
    logic push_ok;
    nb = m_busy;
    if (m_we) nb[m_waddr] = 1'b0;
    if (issue_valid) begin
      if (m_busy[issue_addr]) m_waw = 1'b1;
      nb[issue_addr] = 1'b1;
    end
    m_busy  = nb;
    push_ok = ld_valid && m_ready;
    if (alu_valid) begin
      exp_q.push_back({1'b1, alu_addr, alu_value});
      m_we = 1'b1; m_waddr = alu_addr; m_valu = alu_value; m_sel = 1'b1;
    end else if (m_fifo.size() != 0) begin
      logic [AW+DW-1:0] h;
      h = m_fifo.pop_front();
      exp_q.push_back({1'b0, h});
      m_we = 1'b1; m_waddr = h[AW+DW-1:DW]; m_vid = h[DW-1:0]; m_sel = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (push_ok) m_fifo.push_back({ld_addr, ld_value});
    m_ready  = (m_fifo.size() < 2);
    m_accept = push_ok;
    @(posedge clk); #1;
    compare_outputs();
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    model_clear();
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_addr", 64'(write_addr), 64'd0);
    check("rst_alu", 64'(write_value_alu), 64'd0);
    check("rst_id", 64'(write_value_id), 64'd0);
    check("rst_sel", 64'(write_data_sel), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_waw", 64'(waw_err), 64'd0);
    check("rst_ready", 64'(ld_ready), 64'd0);
    @(posedge clk); @(posedge clk); #2;
    check("rst_ready_hold", 64'(ld_ready), 64'd0);
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    apply_reset();
    tick();                                   // ld_ready rises, no stray write
    tick();

    // ALU write with dependent read
    issue_valid = 1'b1; issue_addr = 3'd3; tick();
    issue_valid = 1'b0; issue_addr = 3'd0; rd_addr1 = 3'd3;
    alu_valid = 1'b1; alu_addr = 3'd3; alu_value = 32'hDEADBEEF; tick();
    alu_valid = 1'b0; tick();
    check("dep_stall_drop", 64'(stall), 64'd0);
    tick();

    // Loads wait behind three ALU cycles
    alu_valid = 1'b1; alu_addr = 3'd5;
    alu_value = 32'h0000_0551; ld_valid = 1'b1; ld_addr = 3'd1; ld_value = 32'h11; tick();
    alu_value = 32'h0000_0552; ld_addr = 3'd2; ld_value = 32'h22; tick();
    check("full_ready", 64'(ld_ready), 64'd0);
    alu_value = 32'h0000_0553; ld_valid = 1'b0; tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Three back-to-back loads under ALU pressure: third waits for room
    pend_ld.delete();
    pend_ld.push_back({3'd6, 32'hA0A0_0006});
    pend_ld.push_back({3'd7, 32'hA0A0_0007});
    pend_ld.push_back({3'd0, 32'hA0A0_0000});
    for (int c = 0; c < 20; c++) begin
      alu_valid = (c < 4); alu_addr = 3'd4; alu_value = 32'hC0DE_0000 + 32'(c);
      ld_valid  = (pend_ld.size() != 0);
      if (ld_valid) {ld_addr, ld_value} = pend_ld[0];
      tick();
      if (m_accept) void'(pend_ld.pop_front());
    end
    check("ld_drain", 64'(pend_ld.size()), 64'd0);
    idle_inputs();
    tick();

    // Hazard: issue r4 twice without writeback
    issue_valid = 1'b1; issue_addr = 3'd4; tick();
    check("hz_stall", 64'(stall), 64'd1);
    tick();
    check("hz_waw", 64'(waw_err), 64'd1);
    issue_valid = 1'b0; alu_valid = 1'b1; alu_addr = 3'd4; alu_value = 32'h4444_4444; tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();   // idle: outputs hold, waw sticky

    // Reset mid-traffic with two loads buffered and busy = 0C
    issue_valid = 1'b1; issue_addr = 3'd2; tick();
    issue_addr = 3'd3; tick();
    issue_valid = 1'b0; issue_addr = 3'd0;
    alu_valid = 1'b1; alu_addr = 3'd1; alu_value = 32'h1234_5678;
    ld_valid = 1'b1; ld_addr = 3'd5; ld_value = 32'h55; tick();
    ld_addr = 3'd6; ld_value = 32'h66; tick();
    check("pre_rst_busy", 64'(busy), 64'h0C);
    apply_reset();
    tick();
    tick();

    // Randomised traffic
    for (int c = 0; c < 60; c++) begin
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_addr    = AW'($urandom_range(0, 7));
      alu_value   = $urandom;
      ld_valid    = ($urandom_range(0, 1) == 1);
      ld_addr     = AW'($urandom_range(0, 7));
      ld_value    = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_addr  = AW'($urandom_range(0, 7));
      rd_addr1    = AW'($urandom_range(0, 7));
      rd_addr2    = AW'($urandom_range(0, 7));
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
